xy2_100_tx: RTL



---
 rtl/xy2_100_tx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/xy2_100_tx.sv
// XY2-100 transmitter: serialises 16-bit X/Y position commands into
// continuous 20-bit frames {CTRL_BITS, pos, even parity}, MSB first.
// Every output is a flop fed from the next-state values, so the pins
// track the state registers cycle for cycle and cannot glitch.
module xy2_100_tx #(
   parameter int           CLK_DIV   = 25,
   parameter logic [2:0]   CTRL_BITS = 3'b001
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [15:0] x_pos,
   input  logic [15:0] y_pos,
   input  logic        pos_valid,
   output logic        frame_start,
   output logic        busy,
   output logic        xy_clk,
   output logic        xy_sync,
   output logic        xy_x_data,
   output logic        xy_y_data
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] PH_HALF = PW'(CLK_DIV / 2);
   localparam logic [4:0]    BIT_LAST = 5'd19;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] phase, phase_nxt;
   logic [4:0]    bit_cnt, bit_cnt_nxt;
   logic [19:0]   sr_x, sr_x_nxt, sr_y, sr_y_nxt;
   logic [15:0]   shd_x, shd_y;
   logic          pending;
   logic [15:0]   ld_x, ld_y;
   logic          clk_nxt, sync_nxt, xd_nxt, yd_nxt, busy_nxt, fs_nxt;

   // Frame word: control bits, position, then parity making the 1-count even.
   function automatic logic [19:0] mk_frame(input logic [15:0] p);
      return {CTRL_BITS, p, ^{CTRL_BITS, p}};
   endfunction

   // Value loaded at LOAD: a same-cycle strobe bypasses the shadow; without a
   // pending update the shift register already holds the last sent position.
   always_comb begin
      ld_x = pos_valid ? x_pos : (pending ? shd_x : sr_x[16:1]);
      ld_y = pos_valid ? y_pos : (pending ? shd_y : sr_y[16:1]);
   end

   // Next-state logic plus next values for the registered outputs.
   always_comb begin
      state_nxt   = state;
      phase_nxt   = phase;
      bit_cnt_nxt = bit_cnt;
      sr_x_nxt    = sr_x;
      sr_y_nxt    = sr_y;
      case (state)
         IDLE: if (en) state_nxt = LOAD;
         LOAD: begin
            sr_x_nxt    = mk_frame(ld_x);
            sr_y_nxt    = mk_frame(ld_y);
            phase_nxt   = '0;
            bit_cnt_nxt = '0;
            state_nxt   = SHIFT;
         end
         SHIFT: begin
            if (phase == PH_LAST) begin
               phase_nxt = '0;
               if (bit_cnt == BIT_LAST) state_nxt = en ? LOAD : IDLE;
               else                     bit_cnt_nxt = bit_cnt + 5'd1;
            end else begin
               phase_nxt = phase + PW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase

      // LOAD holds the line state so data only ever moves at phase 0.
      clk_nxt  = 1'b1;
      sync_nxt = 1'b0;
      xd_nxt   = 1'b0;
      yd_nxt   = 1'b0;
      busy_nxt = 1'b0;
      fs_nxt   = 1'b0;
      case (state_nxt)
         LOAD: begin
            clk_nxt  = xy_clk;
            sync_nxt = xy_sync;
            xd_nxt   = xy_x_data;
            yd_nxt   = xy_y_data;
            busy_nxt = 1'b1;
            fs_nxt   = 1'b1;
         end
         SHIFT: begin
            clk_nxt  = (phase_nxt < PH_HALF);
            sync_nxt = (bit_cnt_nxt != BIT_LAST);
            xd_nxt   = sr_x_nxt[BIT_LAST - bit_cnt_nxt];
            yd_nxt   = sr_y_nxt[BIT_LAST - bit_cnt_nxt];
            busy_nxt = 1'b1;
         end
         default: ;
      endcase
   end

   // State, counters and frame registers.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         phase   <= '0;
         bit_cnt <= '0;
         sr_x    <= '0;
         sr_y    <= '0;
      end else begin
         state   <= state_nxt;
         phase   <= phase_nxt;
         bit_cnt <= bit_cnt_nxt;
         sr_x    <= sr_x_nxt;
         sr_y    <= sr_y_nxt;
      end
   end

   // Shadow capture; LOAD consumes the pending update (and wins over a strobe).
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         shd_x   <= '0;
         shd_y   <= '0;
         pending <= 1'b0;
      end else begin
         if (pos_valid) begin
            shd_x <= x_pos;
            shd_y <= y_pos;
         end
         if (state == LOAD)  pending <= 1'b0;
         else if (pos_valid) pending <= 1'b1;
      end
   end

   // Registered output pins.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         xy_clk      <= 1'b1;
         xy_sync     <= 1'b0;
         xy_x_data   <= 1'b0;
         xy_y_data   <= 1'b0;
         busy        <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         xy_clk      <= clk_nxt;
         xy_sync     <= sync_nxt;
         xy_x_data   <= xd_nxt;
         xy_y_data   <= yd_nxt;
         busy        <= busy_nxt;
         frame_start <= fs_nxt;
      end
   end

endmodule
